// File: rtl/sim_ram_test_sequencer_pkg.sv
// sim_ram_test_pkg: shared types and data-pattern helper for the RAM test sequencer
package sim_ram_test_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} seq_state_e;

    typedef logic [1:0] pass_t;

    localparam int PAT_W = 64;

    // Passes 0/1 use addr^seed, passes 2/3 use its complement; callers truncate to their data width
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr, input pass_t pass,
                                                 input logic [PAT_W-1:0] seed);
        return (pass >= 2'd2) ? ~(addr ^ seed) : (addr ^ seed);
    endfunction

endpackage

// File: rtl/sim_ram_test_sequencer_if.sv
// sim_ram_test_sequencer_if: request/response port between the test sequencer and the simulation RAM
interface sim_ram_test_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    import sim_ram_test_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sim_ram_test_sequencer.sv
// sim_ram_test_sequencer: four-pass write/verify sequencer (pattern, verify, inverted pattern, verify)
module sim_ram_test_sequencer
    import sim_ram_test_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          DATA_WIDTH     = 32,
    parameter int          BASE_ADDR      = 0,
    parameter int          NUM_WORDS      = 1024,
    parameter logic [31:0] SEED           = 32'hA5A5_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    sim_ram_test_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     success,
    output logic [15:0]              error_count,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic                     timeout
);

    // One spare address bit so the last-word compare never wraps
    localparam int             AW1      = ADDR_WIDTH + 1;
    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW1-1:0] LP_BASE  = AW1'(BASE_ADDR);
    localparam logic [AW1-1:0] LP_LAST  = AW1'(BASE_ADDR + NUM_WORDS - 1);
    localparam logic [TW-1:0]  LP_TLAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_e            r_state, w_state;
    logic [AW1-1:0]        r_addr, w_addr;
    pass_t                 r_pass, w_pass;
    logic [15:0]           r_err, w_err;
    logic [ADDR_WIDTH-1:0] r_fail, w_fail;
    logic                  r_timeout, w_timeout;
    logic [TW-1:0]         r_tcnt, w_tcnt;
    logic                  r_done, r_success;
    logic                  w_hs, w_last, w_mis;
    logic [DATA_WIDTH-1:0] w_exp;

    assign w_hs   = bus.req_valid && bus.req_ready;
    assign w_last = r_addr == LP_LAST;
    assign w_exp  = DATA_WIDTH'(pattern(PAT_W'(r_addr[ADDR_WIDTH-1:0]), r_pass, PAT_W'(SEED)));
    assign w_mis  = bus.resp_rdata != w_exp;

    assign bus.req_valid = (r_state == WRITE) || (r_state == READ_REQ);
    assign bus.req_write = r_state == WRITE;
    assign bus.req_addr  = r_addr[ADDR_WIDTH-1:0];
    assign bus.req_wdata = bus.req_write ? w_exp : '0;

    assign busy        = (r_state == WRITE) || (r_state == READ_REQ) || (r_state == READ_WAIT);
    assign done        = r_done;
    assign success     = r_success;
    assign error_count = r_err;
    assign fail_addr   = r_fail;
    assign timeout     = r_timeout;

    // Next-state and datapath updates; everything holds unless the current state acts
    always_comb begin
        w_state   = r_state;
        w_addr    = r_addr;
        w_pass    = r_pass;
        w_err     = r_err;
        w_fail    = r_fail;
        w_timeout = r_timeout;
        w_tcnt    = r_tcnt;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_state   = WRITE;
                w_addr    = LP_BASE;
                w_pass    = '0;
                w_err     = '0;
                w_fail    = '0;
                w_timeout = 1'b0;
            end
            WRITE: if (w_hs) begin
                w_state = w_last ? READ_REQ : WRITE;
                w_addr  = w_last ? LP_BASE : r_addr + AW1'(1);
                w_pass  = w_last ? r_pass + 2'd1 : r_pass;
            end
            READ_REQ: if (w_hs) begin
                w_state = READ_WAIT;
                w_tcnt  = '0;
            end
            READ_WAIT: if (bus.resp_valid) begin
                w_err   = (w_mis && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
                w_fail  = (w_mis && r_err == '0) ? r_addr[ADDR_WIDTH-1:0] : r_fail;
                w_state = !w_last ? READ_REQ : (r_pass == 2'd1 ? WRITE : DONE);
                w_addr  = w_last ? LP_BASE : r_addr + AW1'(1);
                w_pass  = (w_last && r_pass == 2'd1) ? 2'd2 : r_pass;
            end else if (r_tcnt == LP_TLAST) begin
                w_timeout = 1'b1;
                w_state   = DONE;
            end else begin
                w_tcnt = r_tcnt + TW'(1);
            end
            default: w_state = IDLE;
        endcase
    end

    // State and datapath registers; done/success are registered so they rise together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_pass    <= '0;
            r_err     <= '0;
            r_fail    <= '0;
            r_timeout <= 1'b0;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_pass    <= w_pass;
            r_err     <= w_err;
            r_fail    <= w_fail;
            r_timeout <= w_timeout;
            r_tcnt    <= w_tcnt;
            r_done    <= w_state == DONE;
            r_success <= (w_state == DONE) && (w_err == '0) && !w_timeout;
        end
    end

endmodule
